fb_rect_fill: RTL and testbench
===============================

// Module: fb_rect_fill
// PURPOSE
//  Drawing engine on the framebuffer write port: fills an axis-aligned rectangle by
//  issuing one pixel write (x, y, cidx, we) per free cycle, row-major.
//  Sits between the CPU/command logic and the indexed-colour framebuffer in clk_sys.
//  Stalls whenever the framebuffer reports busy; signals completion with a 1-cycle done.
// PARAMETERS
//  CORDW   16   signed coordinate width (bits)
//  WIDTH   320  framebuffer width in pixels (used only with clip feature)
//  HEIGHT  180  framebuffer height in pixels (used only with clip feature)
//  CIDXW   4    colour index width
// PORTS
//  clk_sys    in   1      system clock
//  rst_sys_n  in   1      reset: synchronous, active-low
//  start      in   1      begin fill (sampled in IDLE only)
//  x0,y0      in   CORDW  signed corner A
//  x1,y1      in   CORDW  signed corner B (any order relative to A)
//  cidx_in    in   CIDXW  fill colour index
//  fb_busy    in   1      framebuffer busy; no write may be issued while high
//  we         out  1      pixel write enable
//  x,y        out  CORDW  signed pixel coordinate for write
//  cidx       out  CIDXW  colour index for write
//  drawing    out  1      high from INIT through last write
//  done       out  1      1-cycle pulse after final write (or empty rect)
// BEHAVIOUR
//  - Reset (rst_sys_n=0 at clk edge): state=IDLE; we=0, drawing=0, done=0, x=y=0, cidx=0.
//    Reset mid-fill aborts immediately; no further writes, no done pulse.
//  - States: IDLE -> INIT -> DRAW -> DONE -> IDLE.
//  - IDLE: on start=1 latch x0,y0,x1,y1,cidx_in; go INIT. start in other states ignored.
//  - INIT (1 cycle): xa=min(x0,x1), xb=max, ya=min(y0,y1), yb=max (signed compares);
//    x<=xa, y<=ya; drawing<=1; go DRAW (or DONE if rect empty after clip).
//  - DRAW: we = !fb_busy (combinational on registered state is NOT allowed; we is registered:
//    we<=1 for the current (x,y) in the cycle after fb_busy sampled low).
//    When fb_busy=1: we<=0, x/y held, pixel re-issued once busy falls; no pixel skipped.
//    Advance per issued write: x<=x+1; at x==xb: x<=xa, y<=y+1; at x==xb && y==yb: go DONE.
//  - DONE: drawing<=0, done<=1 for exactly 1 cycle, we<=0; next cycle IDLE.
//  - Throughput 1 pixel/cycle with busy low; total = 1 (INIT) + N pixels + 1 (DONE).
//  - First we asserted 2 cycles after start sampled (start edge, INIT, then DRAW).
//  - Degenerate: x0==x1 and y0==y1 -> exactly 1 write. Arithmetic in CORDW signed;
//    coordinates equal to +max CORDW value are not supported (x+1 overflow).
//  - cidx output constant for the whole fill (latched value).
// CONFIGURATION
//  FB_RECT_FILL_CLIP_EN defined: INIT clamps xa,ya to >=0 and xb,yb to <=WIDTH-1/HEIGHT-1;
//    if clamped rect is empty (xa>xb or ya>yb) go straight to DONE with zero writes.
//    Only on-screen pixels are issued.
//  Not defined: no clamping; every pixel in the rect is issued, off-screen ones included
//    (framebuffer drops them); WIDTH/HEIGHT unused.
// TESTING
//  1 start, (2,3)-(4,4), busy=0 -> 6 writes (2,3)(3,3)(4,3)(2,4)(3,4)(4,4), done 1 cycle after last.
//  2 corners swapped (4,4)-(2,3) -> identical 6-write sequence as test 1.
//  3 busy=1 for 3 cycles during 2nd pixel of test 1 -> we=0 3 cycles, (3,3) re-issued, 6 writes total.
//  4 (5,5)-(5,5) -> single write (5,5); start asserted while drawing -> ignored.
//  5 rst_sys_n=0 mid-fill -> next cycle we=0, drawing=0, no done; new start works normally.
//  6 CLIP_EN, (-2,-1)-(1,0) -> writes (0,0)(1,0) only; (-5,-5)-(-1,-1) -> zero writes, done pulse.

Source files
------------

// File: rtl/fb_rect_fill_if.sv
// rtl/fb_rect_fill_if.sv - fill command inputs and framebuffer pixel-write outputs
// Coordinates are signed so corners may lie off-screen.
interface fb_rect_fill_if #(
  parameter int CORDW = 16,
  parameter int CIDXW = 4
);
  logic                    start;
  logic signed [CORDW-1:0] x0;
  logic signed [CORDW-1:0] y0;
  logic signed [CORDW-1:0] x1;
  logic signed [CORDW-1:0] y1;
  logic [CIDXW-1:0]        cidx_in;
  logic                    fb_busy;
  logic                    we;
  logic signed [CORDW-1:0] x;
  logic signed [CORDW-1:0] y;
  logic [CIDXW-1:0]        cidx;
  logic                    drawing;
  logic                    done;

  modport master (
    output start, x0, y0, x1, y1, cidx_in, fb_busy,
    input  we, x, y, cidx, drawing, done
  );

  modport slave (
    input  start, x0, y0, x1, y1, cidx_in, fb_busy,
    output we, x, y, cidx, drawing, done
  );
endinterface

// File: rtl/fb_rect_fill.sv
// rtl/fb_rect_fill.sv - row-major rectangle fill engine on the framebuffer write port
// Optional on-screen clipping is enabled by defining FB_RECT_FILL_CLIP_EN.
module fb_rect_fill #(
  parameter int CORDW  = 16,
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 180,
  parameter int CIDXW  = 4
) (
  input  logic          clk_sys,
  input  logic          rst_sys_n,
  fb_rect_fill_if.slave bus
);

  if (WIDTH < 1 || HEIGHT < 1) begin : g_bad_dims
    $error("fb_rect_fill: WIDTH and HEIGHT must be positive");
  end

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_DRAW, S_DONE} state_t;

  state_t r_state, w_state_next;

  logic signed [CORDW-1:0] r_x0, r_y0, r_x1, r_y1;
  logic signed [CORDW-1:0] r_xa, r_xb, r_ya, r_yb;
  logic signed [CORDW-1:0] r_cx, r_cy;
  logic signed [CORDW-1:0] r_x, r_y;
  logic [CIDXW-1:0]        r_cidx;
  logic                    r_we, r_drawing, r_done;

  logic signed [CORDW-1:0] w_xa, w_xb, w_ya, w_yb;
  logic                    w_empty, w_last;

`ifdef FB_RECT_FILL_CLIP_EN
  localparam logic signed [CORDW-1:0] C_ZERO = '0;
  localparam logic signed [CORDW-1:0] C_XMAX = CORDW'(WIDTH - 1);
  localparam logic signed [CORDW-1:0] C_YMAX = CORDW'(HEIGHT - 1);
`endif

  // Normalise corners from the latched command; clamp to the screen when clipping.
  always_comb begin
    w_xa = (r_x0 < r_x1) ? r_x0 : r_x1;
    w_xb = (r_x0 < r_x1) ? r_x1 : r_x0;
    w_ya = (r_y0 < r_y1) ? r_y0 : r_y1;
    w_yb = (r_y0 < r_y1) ? r_y1 : r_y0;
`ifdef FB_RECT_FILL_CLIP_EN
    if (w_xa < C_ZERO) w_xa = C_ZERO;
    if (w_ya < C_ZERO) w_ya = C_ZERO;
    if (w_xb > C_XMAX) w_xb = C_XMAX;
    if (w_yb > C_YMAX) w_yb = C_YMAX;
    w_empty = (w_xa > w_xb) || (w_ya > w_yb);
`else
    w_empty = 1'b0;
`endif
  end

  assign w_last = (r_cx == r_xb) && (r_cy == r_yb);

  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_INIT;
      S_INIT:  w_state_next = w_empty ? S_DONE : S_DRAW;
      S_DRAW:  if (!bus.fb_busy && w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Iterator (r_cx/r_cy) runs one pixel ahead of the registered write (r_x/r_y).
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      r_we      <= 1'b0;
      r_drawing <= 1'b0;
      r_done    <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_cidx    <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_x0   <= bus.x0;
            r_y0   <= bus.y0;
            r_x1   <= bus.x1;
            r_y1   <= bus.y1;
            r_cidx <= bus.cidx_in;
          end
        end
        S_INIT: begin
          r_xa      <= w_xa;
          r_xb      <= w_xb;
          r_ya      <= w_ya;
          r_yb      <= w_yb;
          r_cx      <= w_xa;
          r_cy      <= w_ya;
          r_x       <= w_xa;
          r_y       <= w_ya;
          r_drawing <= 1'b1;
        end
        S_DRAW: begin
          if (!bus.fb_busy) begin
            r_we <= 1'b1;
            r_x  <= r_cx;
            r_y  <= r_cy;
            if (r_cx == r_xb) begin
              r_cx <= r_xa;
              r_cy <= r_cy + CORDW'(1);
            end else begin
              r_cx <= r_cx + CORDW'(1);
            end
          end
        end
        S_DONE: begin
          r_drawing <= 1'b0;
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.we      = r_we;
  assign bus.x       = r_x;
  assign bus.y       = r_y;
  assign bus.cidx    = r_cidx;
  assign bus.drawing = r_drawing;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_fb_rect_fill.sv
// tb/tb_fb_rect_fill.sv - directed bench for fb_rect_fill write order, stalls, reset and clipping
// Writes are logged at the falling edge together with the rising-edge count that produced them.
module tb_fb_rect_fill;
  localparam int CORDW = 16;
  localparam int CIDXW = 4;

  logic clk_sys   = 1'b0;
  logic rst_sys_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  fb_rect_fill_if #(.CORDW(CORDW), .CIDXW(CIDXW)) bus ();

  fb_rect_fill #(.CORDW(CORDW), .WIDTH(320), .HEIGHT(180), .CIDXW(CIDXW)) dut (
    .clk_sys  (clk_sys),
    .rst_sys_n(rst_sys_n),
    .bus      (bus)
  );

  typedef struct {int x; int y; int c; int t;} wr_t;

  int  cyc = 0;
  int  busy_from = 0;
  int  busy_to = 0;
  wr_t wq[$];
  int  exp_x[$];
  int  exp_y[$];
  int  n_tests = 0;
  int  n_fail = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (bus.we === 1'b1) wq.push_back('{int'(bus.x), int'(bus.y), int'(bus.cidx), cyc});
  end

  always @(negedge clk_sys) bus.fb_busy = (cyc >= busy_from) && (cyc < busy_to);

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic add_exp(input int xv, input int yv);
    exp_x.push_back(xv);
    exp_y.push_back(yv);
  endtask

  task automatic exp_rect(input int xa, input int ya, input int xb, input int yb);
    for (int yy = ya; yy <= yb; yy++)
      for (int xx = xa; xx <= xb; xx++) add_exp(xx, yy);
  endtask

  task automatic check_writes(input string tag, input int ci, input int t_first);
    int n;
    check({tag, "_count"}, wq.size(), exp_x.size());
    n = (wq.size() < exp_x.size()) ? wq.size() : exp_x.size();
    if (n > 0) check({tag, "_first_t"}, wq[0].t, t_first);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_x%0d", tag, i), wq[i].x, exp_x[i]);
      check($sformatf("%s_y%0d", tag, i), wq[i].y, exp_y[i]);
      check($sformatf("%s_c%0d", tag, i), wq[i].c, ci);
    end
    wq.delete();
    exp_x.delete();
    exp_y.delete();
  endtask

  task automatic start_fill(input int ax, input int ay, input int bx, input int by,
                            input int ci, output int k);
    @(negedge clk_sys);
    bus.x0      = ax[CORDW-1:0];
    bus.y0      = ay[CORDW-1:0];
    bus.x1      = bx[CORDW-1:0];
    bus.y1      = by[CORDW-1:0];
    bus.cidx_in = ci[CIDXW-1:0];
    bus.start   = 1'b1;
    k = cyc + 1;
    @(negedge clk_sys);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      if (bus.done === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
    check({tag, "_done_seen"}, dcyc >= 0, 1);
    if (dcyc >= 0) begin
      @(negedge clk_sys);
      check({tag, "_done_1cyc"}, bus.done, 0);
      check({tag, "_drawing_off"}, bus.drawing, 0);
    end
  endtask

  task automatic t1_expect();
    add_exp(2, 3); add_exp(3, 3); add_exp(4, 3);
    add_exp(2, 4); add_exp(3, 4); add_exp(4, 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d, dn;
    bus.start = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
    bus.cidx_in = '0;
    rst_sys_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_we", bus.we, 0);
    check("rst_drawing", bus.drawing, 0);
    check("rst_done", bus.done, 0);
    check("rst_x", bus.x, 0);
    check("rst_y", bus.y, 0);
    check("rst_cidx", bus.cidx, 0);
    rst_sys_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Basic fill, then swapped corners.
    start_fill(2, 3, 4, 4, 5, k);
    wait_done("t1", d);
    check("t1_done_t", d, k + 8);
    t1_expect();
    check_writes("t1", 5, k + 2);

    start_fill(4, 4, 2, 3, 7, k);
    wait_done("t2", d);
    check("t2_done_t", d, k + 8);
    t1_expect();
    check_writes("t2", 7, k + 2);

    // Busy held for three edges while the second pixel is due.
    start_fill(2, 3, 4, 4, 9, k);
    busy_from = k + 2;
    busy_to   = k + 5;
    wait_done("t3", d);
    busy_from = 0;
    busy_to   = 0;
    check("t3_done_t", d, k + 11);
    if (wq.size() >= 2) check("t3_stall_gap", wq[1].t - wq[0].t, 4);
    t1_expect();
    check_writes("t3", 9, k + 2);

    // Single pixel; start re-asserted with other data while busy drawing.
    @(negedge clk_sys);
    bus.x0 = 16'd5; bus.y0 = 16'd5; bus.x1 = 16'd5; bus.y1 = 16'd5;
    bus.cidx_in = 4'd3;
    bus.start = 1'b1;
    k = cyc + 1;
    @(negedge clk_sys);
    bus.x0 = 16'd9; bus.y0 = 16'd9; bus.x1 = 16'd0; bus.y1 = 16'd0;
    bus.cidx_in = 4'd1;
    @(negedge clk_sys);
    check("t4_drawing", bus.drawing, 1);
    @(negedge clk_sys);
    bus.start = 1'b0;
    wait_done("t4", d);
    check("t4_done_t", d, k + 3);
    repeat (6) @(negedge clk_sys);
    check("t4_idle_drawing", bus.drawing, 0);
    add_exp(5, 5);
    check_writes("t4", 3, k + 2);

    // Reset in the middle of a fill aborts it.
    start_fill(0, 0, 9, 9, 2, k);
    repeat (5) @(negedge clk_sys);
    rst_sys_n = 1'b0;
    @(negedge clk_sys);
    check("t5_we", bus.we, 0);
    check("t5_drawing", bus.drawing, 0);
    check("t5_done", bus.done, 0);
    rst_sys_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_sys);
      if (bus.done === 1'b1) dn++;
    end
    check("t5_no_done", dn, 0);
    add_exp(0, 0); add_exp(1, 0); add_exp(2, 0); add_exp(3, 0);
    check_writes("t5", 2, k + 2);

    start_fill(2, 3, 4, 4, 6, k);
    wait_done("t5b", d);
    check("t5b_done_t", d, k + 8);
    t1_expect();
    check_writes("t5b", 6, k + 2);

    // Partly and wholly off-screen rectangles.
`ifdef FB_RECT_FILL_CLIP_EN
    start_fill(-2, -1, 1, 0, 4, k);
    wait_done("t6a", d);
    check("t6a_done_t", d, k + 4);
    add_exp(0, 0); add_exp(1, 0);
    check_writes("t6a", 4, k + 2);

    start_fill(-5, -5, -1, -1, 8, k);
    wait_done("t6b", d);
    check("t6b_done_t", d, k + 2);
    check_writes("t6b", 8, k + 2);
`else
    start_fill(-2, -1, 1, 0, 4, k);
    wait_done("t6a", d);
    check("t6a_done_t", d, k + 10);
    add_exp(-2, -1); add_exp(-1, -1); add_exp(0, -1); add_exp(1, -1);
    add_exp(-2, 0);  add_exp(-1, 0);  add_exp(0, 0);  add_exp(1, 0);
    check_writes("t6a", 4, k + 2);

    start_fill(-5, -5, -1, -1, 8, k);
    wait_done("t6b", d);
    check("t6b_done_t", d, k + 27);
    exp_rect(-5, -5, -1, -1);
    check_writes("t6b", 8, k + 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
